// File: rtl/keycode_scan_encoder.sv
// PS/2 set-2 scan-code encoder: turns one key event into an E0/F0-prefixed
// byte sequence on a valid/ready byte stream, with a one-entry key holding register.
module keycode_scan_encoder #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_en,
  input  logic [7:0] keycode,
  input  logic       ext,
  input  logic       make,
  input  logic       clear,
  input  logic       scan_ready,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       key_ready,
  output logic       busy,
  output logic       seq_done,
  output logic       overrun
);

  localparam int unsigned GAP_W = 8;
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES == 0) ? GAP_W'(0) : GAP_W'(GAP_CYCLES - 1);
  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_E0   = 3'd1,
    SEND_F0   = 3'd2,
    SEND_CODE = 3'd3,
    GAP       = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       make;
  } key_t;

  state_t           state, state_d, gap_next, gap_next_d, nxt;
  logic [GAP_W-1:0] cnt, cnt_d;
  key_t             cur, cur_d, hold, hold_d, in_key;
  logic             hold_valid, hold_valid_d;
  logic             overrun_d, seq_done_d, scan_valid_d, advance, xfer;
  logic [7:0]       scan_code_d;

  function automatic state_t first_state(input key_t k);
    if (k.ext)        return SEND_E0;
    else if (!k.make) return SEND_F0;
    else              return SEND_CODE;
  endfunction

  assign in_key = '{code: keycode, ext: ext, make: make};
  assign xfer   = scan_valid & scan_ready;
  assign busy   = (state != IDLE) | hold_valid;

  // Registered state and outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gap_next   <= IDLE;
      cnt        <= '0;
      cur        <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      key_ready  <= 1'b1;
      overrun    <= 1'b0;
      seq_done   <= 1'b0;
      scan_valid <= 1'b0;
      scan_code  <= 8'h00;
    end else begin
      state      <= state_d;
      gap_next   <= gap_next_d;
      cnt        <= cnt_d;
      cur        <= cur_d;
      hold       <= hold_d;
      hold_valid <= hold_valid_d;
      key_ready  <= ~hold_valid_d;
      overrun    <= overrun_d;
      seq_done   <= seq_done_d;
      scan_valid <= scan_valid_d;
      scan_code  <= scan_code_d;
    end
  end

  // Next-state, key intake and output decode
  always_comb begin
    state_d      = state;
    gap_next_d   = gap_next;
    cnt_d        = cnt;
    cur_d        = cur;
    hold_d       = hold;
    hold_valid_d = hold_valid;
    overrun_d    = overrun;
    seq_done_d   = 1'b0;
    scan_code_d  = scan_code;
    scan_valid_d = 1'b0;
    advance      = 1'b0;
    nxt          = IDLE;

    case (state)
      IDLE: begin
        if (hold_valid) begin
          cur_d        = hold;
          state_d      = first_state(hold);
          hold_valid_d = 1'b0;
        end else if (key_en) begin
          cur_d   = in_key;
          state_d = first_state(in_key);
        end
      end
      SEND_E0: begin
        advance = xfer;
        nxt     = cur.make ? SEND_CODE : SEND_F0;
      end
      SEND_F0: begin
        advance = xfer;
        nxt     = SEND_CODE;
      end
      SEND_CODE: begin
        advance    = xfer;
        nxt        = IDLE;
        seq_done_d = xfer;
      end
      GAP: begin
        if (cnt == '0) state_d = gap_next;
        else           cnt_d   = GAP_W'(cnt - GAP_W'(1));
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (GAP_CYCLES == 0) begin
        state_d = nxt;
      end else begin
        state_d    = GAP;
        gap_next_d = nxt;
        cnt_d      = GAP_LOAD;
      end
    end

    // Key intake uses registered hold state: a key arriving as the holding register drains is dropped
    if (clear) overrun_d = 1'b0;
    if (key_en) begin
      if (hold_valid) begin
        overrun_d = 1'b1;
      end else if (state != IDLE) begin
        hold_d       = in_key;
        hold_valid_d = 1'b1;
      end
    end

    case (state_d)
      SEND_E0:   begin scan_valid_d = 1'b1; scan_code_d = BYTE_E0;    end
      SEND_F0:   begin scan_valid_d = 1'b1; scan_code_d = BYTE_F0;    end
      SEND_CODE: begin scan_valid_d = 1'b1; scan_code_d = cur_d.code; end
      default:   scan_valid_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_keycode_scan_encoder.sv
// Directed self-checking bench for keycode_scan_encoder; one instance with
// GAP_CYCLES=0 and one with the default gap of 2 share the same stimulus.
module tb_keycode_scan_encoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_en, ext, make, clear, scan_ready;
  logic [7:0] keycode;

  logic [7:0] code0, code2;
  logic       valid0, valid2, kready0, kready2, busy0, busy2;
  logic       done0, done2, ovr0, ovr2;

  int n_pass = 0;
  int n_chk  = 0;

  keycode_scan_encoder #(.GAP_CYCLES(0)) u0 (
    .clk(clk), .reset_n(reset_n), .key_en(key_en), .keycode(keycode), .ext(ext),
    .make(make), .clear(clear), .scan_ready(scan_ready), .scan_code(code0),
    .scan_valid(valid0), .key_ready(kready0), .busy(busy0), .seq_done(done0),
    .overrun(ovr0));

  keycode_scan_encoder #(.GAP_CYCLES(2)) u2 (
    .clk(clk), .reset_n(reset_n), .key_en(key_en), .keycode(keycode), .ext(ext),
    .make(make), .clear(clear), .scan_ready(scan_ready), .scan_code(code2),
    .scan_valid(valid2), .key_ready(kready2), .busy(busy2), .seq_done(done2),
    .overrun(ovr2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_key(input logic [7:0] k, input logic e, input logic m);
    key_en  = 1'b1;
    keycode = k;
    ext     = e;
    make    = m;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [8:0] exp_valid;
  logic [8:0] exp_done;
  logic [7:0] exp_code [9];
  int         nvalid;

  initial begin
    reset_n = 1'b0; key_en = 1'b0; keycode = 8'h00; ext = 1'b0; make = 1'b0;
    clear = 1'b0; scan_ready = 1'b1;
    idle(2);

    // Reset state
    chk("rst_valid", 32'(valid2), 32'd0);
    chk("rst_code", 32'(code2), 32'h00);
    chk("rst_key_ready", 32'(kready2), 32'd1);
    chk("rst_busy", 32'(busy2), 32'd0);
    chk("rst_seq_done", 32'(done2), 32'd0);
    chk("rst_overrun", 32'(ovr2), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Single-byte make with no gap
    drive_key(8'h1C, 1'b0, 1'b1);
    step();
    key_en = 1'b0;
    chk("g0_valid", 32'(valid0), 32'd1);
    chk("g0_code", 32'(code0), 32'h1C);
    chk("g0_done_early", 32'(done0), 32'd0);
    step();
    chk("g0_valid_after", 32'(valid0), 32'd0);
    chk("g0_done", 32'(done0), 32'd1);
    chk("g0_busy", 32'(busy0), 32'd0);
    step();
    chk("g0_done_pulse", 32'(done0), 32'd0);
    idle(5);

    // Extended break with gap 2: E0, gap, F0, gap, 75, done
    exp_valid = 9'b001001001;
    exp_done  = 9'b010000000;
    exp_code[0] = 8'hE0; exp_code[3] = 8'hF0; exp_code[6] = 8'h75;
    drive_key(8'h75, 1'b1, 1'b0);
    step();
    key_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("ext_brk_valid[%0d]", i), 32'(valid2), 32'(exp_valid[i]));
      chk($sformatf("ext_brk_done[%0d]", i), 32'(done2), 32'(exp_done[i]));
      if (exp_valid[i]) chk($sformatf("ext_brk_code[%0d]", i), 32'(code2), 32'(exp_code[i]));
      step();
    end
    idle(3);

    // Back-pressure during F0
    drive_key(8'h4B, 1'b0, 1'b0);
    step();
    key_en = 1'b0;
    scan_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_valid[%0d]", i), 32'(valid2), 32'd1);
      chk($sformatf("stall_code[%0d]", i), 32'(code2), 32'hF0);
      step();
    end
    chk("stall_valid_6th", 32'(valid2), 32'd1);
    chk("stall_code_6th", 32'(code2), 32'hF0);
    scan_ready = 1'b1;
    step();
    chk("stall_gap", 32'(valid2), 32'd0);
    idle(2);
    chk("stall_code_byte_valid", 32'(valid2), 32'd1);
    chk("stall_code_byte", 32'(code2), 32'h4B);
    step();
    chk("stall_done", 32'(done2), 32'd1);
    idle(4);

    // Three back-to-back keys: send, hold, drop
    drive_key(8'h1C, 1'b0, 1'b1);
    step();
    chk("b2b_first_code", 32'(code2), 32'h1C);
    chk("b2b_first_valid", 32'(valid2), 32'd1);
    drive_key(8'h32, 1'b0, 1'b1);
    step();
    chk("b2b_held_key_ready", 32'(kready2), 32'd0);
    chk("b2b_overrun_clear", 32'(ovr2), 32'd0);
    drive_key(8'h21, 1'b0, 1'b1);
    step();
    key_en = 1'b0;
    chk("b2b_overrun", 32'(ovr2), 32'd1);
    chk("b2b_key_ready_low", 32'(kready2), 32'd0);
    step();
    chk("b2b_idle_valid", 32'(valid2), 32'd0);
    chk("b2b_idle_busy", 32'(busy2), 32'd1);
    step();
    chk("b2b_held_valid", 32'(valid2), 32'd1);
    chk("b2b_held_code", 32'(code2), 32'h32);
    chk("b2b_key_ready_back", 32'(kready2), 32'd1);
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (valid2) nvalid++;
    end
    chk("b2b_dropped_not_sent", 32'(nvalid), 32'd0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("b2b_clear", 32'(ovr2), 32'd0);

    // Drop and clear together: overrun set wins
    drive_key(8'h11, 1'b0, 1'b1);
    step();
    drive_key(8'h22, 1'b0, 1'b1);
    step();
    drive_key(8'h33, 1'b0, 1'b1);
    clear = 1'b1;
    step();
    key_en = 1'b0;
    chk("set_wins_overrun", 32'(ovr2), 32'd1);
    step();
    clear = 1'b0;
    chk("clear_alone", 32'(ovr2), 32'd0);
    idle(10);

    // Reset mid-sequence abandons remaining bytes
    drive_key(8'h6B, 1'b1, 1'b0);
    step();
    key_en = 1'b0;
    chk("mid_rst_e0_valid", 32'(valid2), 32'd1);
    chk("mid_rst_e0_code", 32'(code2), 32'hE0);
    step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid2), 32'd0);
    chk("mid_rst_code", 32'(code2), 32'h00);
    chk("mid_rst_key_ready", 32'(kready2), 32'd1);
    chk("mid_rst_busy", 32'(busy2), 32'd0);
    chk("mid_rst_seq_done", 32'(done2), 32'd0);
    chk("mid_rst_overrun", 32'(ovr2), 32'd0);
    idle(2);
    reset_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (valid2) nvalid++;
    end
    chk("mid_rst_no_resume", 32'(nvalid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
